inv_sub_bytes: RTL and testbench
================================

// Module: inv_sub_bytes
// PURPOSE
//   AES-128 decryption-path InvSubBytes stage, the inverse of the encrypt-side byte-serial SubBytes.
//   Captures a 128-bit state on start and substitutes one byte per cycle through the inverse S-box.
//   Raises finish when all 16 bytes are done. Sits between InvShiftRows and AddRoundKey in the decrypt round controller.
// PARAMETERS
//   NBYTES   16   bytes per state; counter width = $clog2(NBYTES)+1; only 16 is supported for AES-128
// PORTS
//   clk             in   1    single clock, rising edge
//   rst_n           in   1    asynchronous, active-low reset
//   strt            in   1    level start/enable; must stay high until finish_inv_sub is seen
//   data            in   128  input state; byte i = data[8*i +: 8], byte 0 processed first
//   finish_inv_sub  out  1    high when stt_mat holds the complete result
//   stt_mat         out  128  substituted state; byte i = inv_sbox(data byte i)
// BEHAVIOUR
//   Reset (rst_n=0, any time): state=IDLE, byte_cnt=0, capture reg=0, stt_mat=0, finish_inv_sub=0.
//   FSM states: IDLE, RUN, DONE.
//   IDLE, strt=1 at an edge: capture data into an internal reg, byte_cnt=0, go to RUN.
//     Later changes to data are ignored until the next start.
//   IDLE, strt=0: hold. stt_mat keeps its last value.
//   RUN, strt=1, each edge: stt_mat[8*byte_cnt +: 8] <= inv_sbox(cap[8*byte_cnt +: 8]); byte_cnt++.
//     The edge that writes byte NBYTES-1 also sets finish_inv_sub=1 and goes to DONE.
//   Latency (base build): capture edge = E0; bytes written at E1..E16; finish_inv_sub high after E16.
//   DONE, strt=1: hold stt_mat and finish_inv_sub=1. No re-capture.
//   DONE, strt=0: go to IDLE, finish_inv_sub=0. stt_mat is retained.
//   strt=0 during RUN (abort): next edge goes to IDLE with byte_cnt=0 and finish_inv_sub=0.
//     Bytes already written stay in stt_mat; unwritten bytes keep their prior values.
//   strt re-asserted on the first cycle back in IDLE: starts a fresh capture (no extra idle cycle needed).
//   byte_cnt never exceeds NBYTES-1 as an index; there is no wrap, and DONE is terminal until strt drops.
//   Async reset mid-RUN overrides everything at once. The capture is discarded.
// CONFIGURATION
//   INV_SUB_REG_OUT_EN defined:
//     inv_sbox output goes through one pipeline register (byte value plus index) before the stt_mat write.
//     Every byte is written one edge later; finish rises after E17 (latency +1).
//     RUN lasts one extra cycle to drain the pipeline.
//     On abort, the in-flight pipeline byte is dropped (not written).
//   INV_SUB_REG_OUT_EN undefined: combinational inv_sbox feeds the write directly; latency as above.
// STRUCTURE
//   Shared package aes_pkg:
//     AES_NBYTES=16, AES_STATE_W=128.
//     INV_SBOX[0:255] constant table (FIPS-197 Fig.14), alongside the existing forward table.
//     state enum {IDLE, RUN, DONE} typedef.
//   Sub-module inv_sbox: combinational, ports addr[7:0] -> dout[7:0], a ROM from aes_pkg::INV_SBOX.
//     Exactly one instance, with its address muxed by byte_cnt.
//   Top holds only the FSM, counter, capture reg and output byte-write logic.
// TESTING
//   T1 (FIPS-197 inverse-table check):
//     data=128'h76abd7fe2b670130c56f6bf27b777c63, strt held high.
//     -> stt_mat=128'h0f0e0d0c0b0a09080706050403020100.
//     -> finish_inv_sub rises exactly 16 edges after capture (17 with INV_SUB_REG_OUT_EN).
//   T2 (all-same bytes): data={16{8'h63}} -> stt_mat=0. Then data={16{8'h16}} -> stt_mat={16{8'hff}}.
//   T3 (abort): drop strt after 5 RUN edges.
//     -> next edge IDLE, finish stays 0, stt_mat bytes 0..4 updated, bytes 5..15 unchanged.
//     -> restart completes normally with the full result.
//   T4 (async reset): assert rst_n=0 mid-RUN, off a clock edge.
//     -> outputs 0 immediately; after release, IDLE waits for strt.
//   T5 (DONE hold / restart):
//     -> data changes while in DONE do not alter stt_mat.
//     -> strt low for 1 cycle then high -> new capture and a correct second result.
//   T6 (round trip): encrypt-side SubBytes output fed to inv_sub_bytes -> original random state, 1000 vectors.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants: state geometry, forward and inverse S-box tables,
// and the byte-serial stage FSM state type.
package aes_pkg;

    localparam int AES_NBYTES  = 16;
    localparam int AES_STATE_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Forward S-box, used by the encrypt-side SubBytes stage.
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Inverse S-box (FIPS-197 Fig. 14), used by the decrypt-side InvSubBytes stage.
    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/inv_sbox.sv
// Combinational inverse S-box ROM: one byte in, one substituted byte out.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] addr,
    output logic [7:0] dout
);

    assign dout = INV_SBOX[addr];

endmodule

// File: rtl/inv_sub_bytes.sv
// Byte-serial InvSubBytes stage: captures a 128-bit state on strt, then
// substitutes one byte per cycle through a single shared inverse S-box and
// raises finish_inv_sub once all bytes are written.
// Optional build macro INV_SUB_REG_OUT_EN: registers the S-box output
// (byte value plus index) before the stt_mat write, adding one cycle of latency.
module inv_sub_bytes
    import aes_pkg::*;
#(
    parameter int NBYTES = AES_NBYTES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  strt,
    input  logic [8*NBYTES-1:0]   data,
    output logic                  finish_inv_sub,
    output logic [8*NBYTES-1:0]   stt_mat
);

    localparam int CNT_W = $clog2(NBYTES) + 1;
    localparam int IDX_W = CNT_W - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t               state, state_nx;
    logic [CNT_W-1:0]     byte_cnt, cnt_nx;
    logic [8*NBYTES-1:0]  cap;
    logic                 capture;
    logic [IDX_W-1:0]     idx;
    logic [7:0]           sbox_dout;
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_idx;
    logic [7:0]           wr_val;

    assign idx = byte_cnt[IDX_W-1:0];

    inv_sbox u_inv_sbox (
        .addr (cap[8*idx +: 8]),
        .dout (sbox_dout)
    );

`ifdef INV_SUB_REG_OUT_EN
    logic             issue;
    logic             pipe_vld;
    logic [IDX_W-1:0] pipe_idx;
    logic [7:0]       pipe_val;

    // Output pipeline stage; an abort clears the valid bit so the in-flight byte is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= 1'b0;
            pipe_idx <= '0;
            pipe_val <= '0;
        end else begin
            pipe_vld <= issue;
            if (issue) begin
                pipe_idx <= idx;
                pipe_val <= sbox_dout;
            end
        end
    end
`endif

    // Next-state, counter and byte-write decode.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value unassigned (no latches).
        state_nx = state;
        cnt_nx   = byte_cnt;
        capture  = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = idx;
        wr_val   = sbox_dout;
`ifdef INV_SUB_REG_OUT_EN
        issue    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (strt) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                    capture  = 1'b1;
                end
            end
            RUN: begin
                if (!strt) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
`ifdef INV_SUB_REG_OUT_EN
                    issue  = (byte_cnt < CNT_W'(NBYTES));
                    if (issue) cnt_nx = byte_cnt + CNT_W'(1);
                    wr_en  = pipe_vld;
                    wr_idx = pipe_idx;
                    wr_val = pipe_val;
                    if (pipe_vld && pipe_idx == LAST_IDX) begin
                        state_nx = DONE;
                        cnt_nx   = '0;
                    end
`else
                    wr_en  = 1'b1;
                    cnt_nx = byte_cnt + CNT_W'(1);
                    if (idx == LAST_IDX) begin
                        state_nx = DONE;
                        cnt_nx   = '0;
                    end
`endif
                end
            end
            DONE: begin
                if (!strt) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // State, counter, capture register, result bytes and finish flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            byte_cnt       <= '0;
            cap            <= '0;
            stt_mat        <= '0;
            finish_inv_sub <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state          <= state_nx;
            byte_cnt       <= cnt_nx;
            finish_inv_sub <= (state_nx == DONE);
            if (capture) cap <= data;
            if (wr_en) stt_mat[8*wr_idx +: 8] <= wr_val;
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Self-checking bench for inv_sub_bytes. The reference S-boxes are derived
// from GF(2^8) inversion plus the AES affine map, independent of the RTL tables.
`timescale 1ns/1ps
module tb_inv_sub_bytes;

`ifdef INV_SUB_REG_OUT_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 16;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         strt = 1'b0;
    logic [127:0] data = '0;
    logic         finish_inv_sub;
    logic [127:0] stt_mat;

    int checks = 0;
    int errors = 0;

    logic [7:0]   fwd_tab [256];
    logic [7:0]   inv_tab [256];
    logic [127:0] model_stt;

    typedef struct {
        string        name;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    inv_sub_bytes dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .strt           (strt),
        .data           (data),
        .finish_inv_sub (finish_inv_sub),
        .stt_mat        (stt_mat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    function automatic logic [7:0] sbox_math(input logic [7:0] x);
        logic [7:0] b = 8'h00;
        if (x != 0)
            for (int y = 1; y < 256; y++)
                if (gmul(x, 8'(y)) == 8'h01) b = 8'(y);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] apply_tab(input logic [127:0] s, input logic fwd);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = fwd ? fwd_tab[s[8*i +: 8]] : inv_tab[s[8*i +: 8]];
        return r;
    endfunction

    // Start from IDLE with data d, wait for finish, check latency and result.
    task automatic run_op(input string name, input logic [127:0] d, input logic [127:0] exp);
        int lat = 0;
        @(negedge clk);
        data = d;
        strt = 1'b1;
        @(posedge clk);
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (finish_inv_sub) break;
        end
        check({name, "_lat"}, 128'(lat), 128'(LAT));
        check({name, "_res"}, stt_mat, exp);
        model_stt = exp;
    endtask

    // Drop strt for one edge; DUT returns to IDLE with finish low.
    task automatic drop_strt(input string name);
        @(negedge clk);
        strt = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_fin_low"}, 128'(finish_inv_sub), 128'(0));
    endtask

    initial begin
        vec_t vecs [4];
        logic [127:0] d, pt, held, exp_mix;
        int nwr;

        for (int x = 0; x < 256; x++) fwd_tab[x] = sbox_math(8'(x));
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

        vecs[0] = '{"t1_fips",  128'h76abd7fe2b670130c56f6bf27b777c63, 128'h0f0e0d0c0b0a09080706050403020100};
        vecs[1] = '{"t2_all63", {16{8'h63}}, 128'h0};
        vecs[2] = '{"t2_all16", {16{8'h16}}, {16{8'hff}}};
        vecs[3] = '{"all00",    128'h0,      {16{8'h52}}};

        // Reset state
        #12;
        check("rst_stt", stt_mat, 128'h0);
        check("rst_fin", 128'(finish_inv_sub), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_stt = '0;

        // T1/T2 table
        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].din, vecs[i].exp);
            drop_strt(vecs[i].name);
        end

        // T3 abort after 5 RUN edges
        d = {$urandom, $urandom, $urandom, $urandom};
        held = model_stt;
        nwr = (LAT == 16) ? 5 : 4;
        exp_mix = held;
        for (int i = 0; i < nwr; i++) exp_mix[8*i +: 8] = inv_tab[d[8*i +: 8]];
        @(negedge clk);
        data = d;
        strt = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        strt = 1'b0;
        @(posedge clk);
        #1;
        check("t3_fin", 128'(finish_inv_sub), 128'(0));
        check("t3_partial", stt_mat, exp_mix);
        repeat (2) @(posedge clk);
        #1;
        check("t3_idle_hold", stt_mat, exp_mix);
        run_op("t3_restart", d, apply_tab(d, 1'b0));
        drop_strt("t3");

        // T4 async reset mid-RUN, off a clock edge
        d = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        data = d;
        strt = 1'b1;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t4_rst_stt", stt_mat, 128'h0);
        check("t4_rst_fin", 128'(finish_inv_sub), 128'(0));
        @(negedge clk);
        strt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t4_idle_stt", stt_mat, 128'h0);
        check("t4_idle_fin", 128'(finish_inv_sub), 128'(0));
        run_op("t4_after", d, apply_tab(d, 1'b0));

        // T5 data changes while in DONE are ignored; restart after 1-cycle drop
        held = model_stt;
        @(negedge clk);
        data = ~d;
        repeat (5) @(posedge clk);
        #1;
        check("t5_hold_stt", stt_mat, held);
        check("t5_hold_fin", 128'(finish_inv_sub), 128'(1));
        drop_strt("t5");
        check("t5_retain", stt_mat, held);
        d = {$urandom, $urandom, $urandom, $urandom};
        run_op("t5_second", d, apply_tab(d, 1'b0));
        drop_strt("t5b");

        // T6 round trip through the forward S-box
        for (int n = 0; n < 1000; n++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            run_op("t6_rt", apply_tab(pt, 1'b1), pt);
            @(negedge clk);
            strt = 1'b0;
            @(posedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
